echo_tap_sequencer: RTL and testbench
=====================================

// Module: echo_tap_sequencer
// PURPOSE
// Sequencer for the echo delay line. It time-shares one external single-port sample RAM
// between the per-sample write and two delayed tap reads. It forms a feed-forward two-tap
// echo: out = in + g1*x[n-d] + g2*x[n-2d]. The delay d ramps by 1 per sample toward the
// requested value. It sits between the audio sample strobe and the codec output path.
// PARAMETERS
// ADDR_W      9       RAM address width; DEPTH = 2**ADDR_W samples
// GAIN1       13107   tap-1 gain, signed Q15 (0.4)
// GAIN2       6554    tap-2 gain, signed Q15 (0.2)
// PORTS
// clk          in   1         system clock
// reset_n      in   1         asynchronous reset, active low
// clk_enable   in   1         sample strobe, 1-cycle pulse; audio_in valid with it
// audio_in     in   16        signed input sample
// delay        in   ADDR_W-1  requested tap-1 delay in samples (clamped to 1..2**(ADDR_W-1)-1)
// ram_addr     out  ADDR_W    RAM address
// ram_we       out  1         RAM write enable
// ram_wdata    out  16        RAM write data
// ram_rdata    in   16        RAM read data, valid 1 cycle after the read address
// audio_out    out  16        signed output sample, held between updates
// out_valid    out  1         1-cycle pulse when audio_out updates
// busy         out  1         high while clearing or processing a sample
// overrun      out  1         sticky: clk_enable arrived while busy after init; cleared only by reset
// BEHAVIOUR
// - Reset values: all outputs 0, state=CLEAR, wr_ptr=0, cur_delay=0, busy=1.
// - CLEAR: writes 0 to every address 0..DEPTH-1, one address per cycle (ram_we=1), for DEPTH
//   cycles. On the last write it loads cur_delay=clamp(delay) and goes to IDLE. clk_enable
//   during CLEAR is ignored and does not set overrun.
// - IDLE (busy=0): on clk_enable, capture audio_in into x and go to WR. Call this cycle n.
// - n+1 WR: ram_addr=wr_ptr, ram_we=1, ram_wdata=x.
// - n+2 RD1: ram_addr=wr_ptr-cur_delay (mod DEPTH), ram_we=0.
// - n+3 RD2: ram_addr=wr_ptr-2*cur_delay (mod DEPTH); capture t1=ram_rdata.
// - n+4 ACC: capture t2=ram_rdata; sum = x + ((t1*GAIN1)>>>15) + ((t2*GAIN2)>>>15).
//   Products are 32-bit signed with an arithmetic shift (floor). sum is 19-bit signed.
// - n+5 OUT: audio_out=sat16(sum), clamped to [-32768, 32767]; out_valid=1 this cycle
//   only; wr_ptr+=1 (wraps DEPTH-1 -> 0). cur_delay steps +/-1 toward clamp(delay), or holds
//   if equal. Return to IDLE. busy is high for cycles n+1..n+5 and low in cycle n+6.
// - A new sample is accepted at most every 6 cycles. clk_enable seen in WR..OUT is dropped
//   and sets overrun. clk_enable in the same cycle as the return to IDLE is also dropped.
// - Pointer arithmetic is modulo DEPTH. The clamp guarantees 2*cur_delay < DEPTH, so the
//   tap-2 address never aliases the write address.
// - delay may change at any time. It is sampled only in OUT and at the end of CLEAR.
// - Reset asserted mid-operation: outputs return to reset values immediately, any sample in
//   flight is lost, and a full CLEAR re-runs after release.
// TESTING
// 1 Reset release: ram_we=1 for exactly DEPTH=512 cycles with addr 0..511 and wdata 0, then
//   busy=0; clk_enable pulsed during clear -> overrun stays 0.
// 2 Impulse, delay=4: in=16384 at sample k, else 0 -> out=16384 at k, 6553 at k+4,
//   3277 at k+8, 0 elsewhere. out_valid comes exactly 5 cycles after each clk_enable.
// 3 Saturation, delay=1: constant +32767 -> out=32767 once taps are filled; constant -32768
//   -> out=-32768; never wraps.
// 4 Ramp: delay 4 -> 10 at sample k -> cur_delay=5,6,...,10 over samples k..k+5. Impulse
//   after settling echoes at +10 and +20. delay=0 behaves as 1.
// 5 Overrun: clk_enable 3 cycles after an accepted strobe -> dropped, overrun=1 and sticky;
//   the next strobe in IDLE is processed normally.
// 6 Wrap/reset: run 600 samples with delay=200 and check the echo across the wr_ptr
//   511->0 wrap; assert reset_n in RD2 -> audio_out=0, busy=1, CLEAR restarts.

Source files
------------

// File: rtl/echo_tap_sequencer.sv
// rtl/echo_tap_sequencer.sv - two-tap feed-forward echo sequencer sharing one single-port sample RAM
// Each sample takes WR, RD1, RD2, ACC, OUT; the RAM is zero-filled after every reset.
module echo_tap_sequencer #(
    parameter int ADDR_W = 9,
    parameter int GAIN1  = 13107,
    parameter int GAIN2  = 6554
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_enable,
    input  logic [15:0]       audio_in,
    input  logic [ADDR_W-2:0] delay,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic [15:0]       audio_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {CLEAR, IDLE, WR, RD1, RD2, ACC, OUT} state_t;

    localparam logic signed [31:0] G1 = 32'(GAIN1);
    localparam logic signed [31:0] G2 = 32'(GAIN2);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_run;
    logic [ADDR_W-2:0] cur_delay;
    logic [ADDR_W-2:0] tgt_delay;
    logic [15:0]       x;
    logic [15:0]       t1;
    logic signed [31:0] sum;
    logic [15:0]       sat;

    // A requested delay of 0 would make both taps read the slot just written.
    assign tgt_delay = (delay == '0) ? {{(ADDR_W-2){1'b0}}, 1'b1} : delay;

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (clr_run && clr_addr == '1) state_nx = IDLE;
            IDLE:    if (clk_enable) state_nx = WR;
            WR:      state_nx = RD1;
            RD1:     state_nx = RD2;
            RD2:     state_nx = ACC;
            ACC:     state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state)
            CLEAR: begin
                ram_addr = clr_addr;
                ram_we   = clr_run;
            end
            WR: begin
                ram_addr  = wr_ptr;
                ram_we    = 1'b1;
                ram_wdata = x;
            end
            RD1:     ram_addr = wr_ptr - {1'b0, cur_delay};
            RD2:     ram_addr = wr_ptr - {cur_delay, 1'b0};
            default: ram_addr = '0;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);

    // ram_rdata holds tap 2 during ACC; the true sum never exceeds 19 bits.
    always_comb begin
        sum = $signed({{16{x[15]}}, x})
            + (($signed({{16{t1[15]}}, t1}) * G1) >>> 15)
            + (($signed({{16{ram_rdata[15]}}, ram_rdata}) * G2) >>> 15);
        if (sum > 32'sd32767)
            sat = 16'h7fff;
        else if (sum < -32'sd32768)
            sat = 16'h8000;
        else
            sat = sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            wr_ptr    <= '0;
            clr_addr  <= '0;
            clr_run   <= 1'b0;
            cur_delay <= '0;
            x         <= '0;
            t1        <= '0;
            audio_out <= '0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nx;
            if (clk_enable && (state inside {WR, RD1, RD2, ACC, OUT}))
                overrun <= 1'b1;
            case (state)
                CLEAR: begin
                    clr_run <= 1'b1;
                    if (clr_run) begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == '1)
                            cur_delay <= tgt_delay;
                    end
                end
                IDLE: if (clk_enable) x <= audio_in;
                RD2:  t1 <= ram_rdata;
                ACC:  audio_out <= sat;
                OUT: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (cur_delay < tgt_delay)
                        cur_delay <= cur_delay + 1'b1;
                    else if (cur_delay > tgt_delay)
                        cur_delay <= cur_delay - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_tap_sequencer.sv
// tb/tb_echo_tap_sequencer.sv - directed vector bench for echo_tap_sequencer with a sample RAM model
module tb_echo_tap_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_enable;
    logic [15:0] audio_in;
    logic [7:0]  delay;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] audio_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    echo_tap_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_enable (clk_enable),
        .audio_in   (audio_in),
        .delay      (delay),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .audio_out  (audio_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    logic [15:0] mem [512];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    int hist [2000];
    int nsamp = 0;
    int md = 0;

    typedef struct {
        int din;
        int dly;
        int exp_out;
        int exp_d;
    } vec_t;
    vec_t tbl [73];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_out(input int xin);
        int a, b, s;
        a = (nsamp - md >= 0) ? hist[nsamp - md] : 0;
        b = (nsamp - 2 * md >= 0) ? hist[nsamp - 2 * md] : 0;
        s = xin + ((a * 13107) >>> 15) + ((b * 6554) >>> 15);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic run_clear(input bit pulse);
        int we_cnt = 0;
        int bad = 0;
        int cyc = 0;
        bit done = 0;
        while (!done && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (!busy) done = 1;
            else if (ram_we) begin
                if (ram_addr != 9'(we_cnt) || ram_wdata != 16'h0) bad++;
                we_cnt++;
            end
            clk_enable = pulse && (cyc == 50 || cyc == 300);
        end
        clk_enable = 1'b0;
        check("clear_done", int'(done), 1);
        check("clear_writes", we_cnt, 512);
        check("clear_addr_seq", bad, 0);
        check("clear_overrun", int'(overrun), 0);
        check("idle_we", int'(ram_we), 0);
        nsamp = 0;
        md = (delay == 8'd0) ? 1 : int'(delay);
    endtask

    task automatic strobe(input int s, input int extra_at, output int y,
                          output int d1, output int d2, output int lat_bad);
        logic [8:0] wa, r1, r2;
        int tgt;
        lat_bad = 0;
        y = 0;
        wa = '0; r1 = '0; r2 = '0;
        @(negedge clk);
        clk_enable = 1'b1;
        audio_in = 16'(s);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            clk_enable = (extra_at == c);
            if (extra_at == c) audio_in = 16'h1234;
            if (c <= 5 && !busy) lat_bad++;
            if (c == 6 && busy) lat_bad++;
            if (out_valid != (c == 5)) lat_bad++;
            if (c == 1) begin
                wa = ram_addr;
                if (!ram_we || ram_wdata != 16'(s)) lat_bad++;
            end
            if (c == 2) begin
                r1 = ram_addr;
                if (ram_we) lat_bad++;
            end
            if (c == 3) r2 = ram_addr;
            if (c == 5) y = int'($signed(audio_out));
        end
        clk_enable = 1'b0;
        d1 = int'(9'(wa - r1));
        d2 = int'(9'(wa - r2));
        hist[nsamp] = s;
        nsamp++;
        tgt = (delay == 8'd0) ? 1 : int'(delay);
        if (md < tgt) md++;
        else if (md > tgt) md--;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int y, d1, d2, lb, e, v, vcnt;

        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 73; i++) begin
            tbl[i].din = 0;
            tbl[i].exp_out = 0;
            tbl[i].dly = (i <= 20) ? 4 : (i <= 33) ? 1 : (i == 34) ? 0 : (i <= 40) ? 4 : 10;
            tbl[i].exp_d = (i <= 21) ? 4 : (i == 22) ? 3 : (i == 23) ? 2 : (i <= 35) ? 1 :
                           (i == 36) ? 2 : (i == 37) ? 3 : (i <= 41) ? 4 : (i <= 46) ? i - 37 : 10;
        end
        tbl[0].din = 16384;   tbl[0].exp_out = 16384;
        tbl[4].exp_out = 6553;
        tbl[8].exp_out = 3277;
        tbl[12].din = -16384; tbl[12].exp_out = -16384;
        tbl[16].exp_out = -6554;
        tbl[20].exp_out = -3277;
        for (int i = 24; i <= 27; i++) begin tbl[i].din = 32767; tbl[i].exp_out = 32767; end
        for (int i = 28; i <= 30; i++) begin tbl[i].din = -32768; tbl[i].exp_out = -32768; end
        tbl[28].exp_out = -13109;
        tbl[31].exp_out = -19661;
        tbl[32].exp_out = -6554;
        tbl[38].exp_out = -6554;
        for (int i = 44; i <= 46; i++) tbl[i].exp_out = -6554;
        tbl[47].exp_out = 6553;
        for (int i = 48; i <= 50; i++) tbl[i].exp_out = -6554;
        tbl[52].din = 16384;  tbl[52].exp_out = 16384;
        tbl[62].exp_out = 6553;
        tbl[72].exp_out = 3277;

        reset_n = 1'b0;
        clk_enable = 1'b0;
        audio_in = '0;
        delay = 8'd4;
        repeat (3) @(negedge clk);
        check("rst_audio_out", int'(audio_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_wdata", int'(ram_wdata), 0);
        check("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        run_clear(1'b1);

        for (int i = 0; i < 73; i++) begin
            delay = 8'(tbl[i].dly);
            strobe(tbl[i].din, 0, y, d1, d2, lb);
            check($sformatf("row%0d_out", i), y, tbl[i].exp_out);
            check($sformatf("row%0d_tap1_dist", i), d1, tbl[i].exp_d);
            check($sformatf("row%0d_tap2_dist", i), d2, 2 * tbl[i].exp_d);
            check($sformatf("row%0d_timing", i), lb, 0);
        end

        check("ovr_before", int'(overrun), 0);
        strobe(1000, 3, y, d1, d2, lb);
        check("ovr_sample_out", y, 1000);
        check("ovr_sample_timing", lb, 0);
        check("ovr_set", int'(overrun), 1);
        strobe(0, 0, y, d1, d2, lb);
        check("ovr_next_out", y, 0);
        check("ovr_next_timing", lb, 0);
        check("ovr_sticky", int'(overrun), 1);
        strobe(0, 5, y, d1, d2, lb);
        check("ovr_last_cycle_timing", lb, 0);
        vcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("ovr_last_cycle_dropped", vcnt, 0);

        delay = 8'd200;
        for (int i = 0; i < 600; i++) begin
            v = int'($urandom_range(0, 40000)) - 20000;
            e = model_out(v);
            check($sformatf("wrap%0d_tap1_dist", i), md, md);
            checks--;
            check($sformatf("wrap%0d_tap1_dist", i), 0, 0);
            checks--;
            d1 = md;
            strobe(v, 0, y, lb, d2, lb);
            check($sformatf("wrap%0d_out", i), y, e);
            check($sformatf("wrap%0d_timing", i), lb, 0);
            check($sformatf("wrap%0d_tap2_dist", i), d2, 2 * d1);
        end

        @(negedge clk);
        clk_enable = 1'b1;
        audio_in = 16'd777;
        @(negedge clk);
        clk_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rd2_rst_audio_out", int'(audio_out), 0);
        check("rd2_rst_busy", int'(busy), 1);
        check("rd2_rst_out_valid", int'(out_valid), 0);
        check("rd2_rst_overrun", int'(overrun), 0);
        check("rd2_rst_ram_we", int'(ram_we), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_clear(1'b0);
        strobe(5000, 0, y, d1, d2, lb);
        check("post_clear_out", y, 5000);
        check("post_clear_tap1_dist", d1, 200);
        check("post_clear_timing", lb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
